stopwatch_ctrl: RTL and testbench

Control sequencer for the CNT60 stopwatch datapath. Conditions three raw push-buttons (synchronise, debounce, detect press) and runs a four-state run/pause/lap state machine. Gates the 1 Hz enable tick from the enable generator into the seconds/minutes counter chain, and issues clear and display-hold commands to it. Sits between the board buttons / enable generator and the CNT60 counter chain.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/btn_cond.sv | 40 ++++
 rtl/stopwatch_ctrl.sv | 74 +++++++
 tb/tb_stopwatch_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and default button-conditioning timing
// for the CNT60 stopwatch control sequencer.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;
  // 10 ms of stable input at 12 MHz
  localparam int DEB_CYCLES_DEF = 120000;
  localparam int DEB_W_DEF      = 17;
  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction
endpackage

// File: rtl/btn_cond.sv
// btn_cond: 2-FF synchroniser, counter debounce and one-cycle press detect
// for a single raw active-high push-button.
module btn_cond
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);
  logic [1:0]       sync_q;
  logic             lvl_q, lvl_d, prev_q, press_q, differ, done;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  // any sample matching the accepted level restarts the stability count
  always_comb begin
    differ = sync_q[1] != lvl_q;
    done   = differ && (cnt_q == DEB_W'(DEB_CYCLES - 1));
    lvl_d  = done ? sync_q[1] : lvl_q;
    cnt_d  = (!differ || done) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      prev_q  <= lvl_q;
      press_q <= lvl_q & ~prev_q;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/lap/pause/idle sequencer that gates the 1 Hz tick into
// the CNT60 counter chain and drives its clear and display-hold controls.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic SEC_EN,
  input  logic BTN_SS,
  input  logic BTN_LAP,
  input  logic BTN_CLR,
  output logic CNT_EN,
  output logic CNT_CLR,
  output logic HOLD,
  output logic RUN_LED
);
  state_t state_q, state_d;
  logic   ss_p, lap_p, clr_p;
  logic   cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d, hold_q, hold_d, run_q, run_d;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_ss (
    .clk_i(CLK), .rst_ni(RESET_N), .btn_i(BTN_SS), .press_o(ss_p)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_lap (
    .clk_i(CLK), .rst_ni(RESET_N), .btn_i(BTN_LAP), .press_o(lap_p)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_clr (
    .clk_i(CLK), .rst_ni(RESET_N), .btn_i(BTN_CLR), .press_o(clr_p)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      hold_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      hold_q    <= hold_d;
      run_q     <= run_d;
    end
  end

  // CLR only matters while stopped, so a CLR pulse never masks SS in RUN/LAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = clr_p ? IDLE  : ss_p ? RUN   : IDLE;
      RUN:     state_d = ss_p  ? PAUSE : lap_p ? LAP  : RUN;
      LAP:     state_d = ss_p  ? PAUSE : lap_p ? RUN  : LAP;
      PAUSE:   state_d = clr_p ? IDLE  : ss_p ? RUN   : PAUSE;
      default: state_d = IDLE;
    endcase
  end

  // the tick is gated by the pre-transition state
  always_comb begin
    cnt_en_d  = SEC_EN && is_counting(state_q);
    cnt_clr_d = clr_p && (state_q == IDLE || state_q == PAUSE);
    hold_d    = state_d == LAP;
    run_d     = is_counting(state_d);
  end

  assign CNT_EN  = cnt_en_q;
  assign CNT_CLR = cnt_clr_q;
  assign HOLD    = hold_q;
  assign RUN_LED = run_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with a 4-cycle debounce
// and a periodic 10-cycle SEC_EN tick.
module tb_stopwatch_ctrl;
  logic CLK = 1'b0, RESET_N = 1'b0, SEC_EN = 1'b0;
  logic BTN_SS = 1'b0, BTN_LAP = 1'b0, BTN_CLR = 1'b0;
  logic CNT_EN, CNT_CLR, HOLD, RUN_LED;
  int   errs = 0, checks = 0, t = 0, n_en = 0, n_clr = 0;
  bit   sec_auto = 1'b0;

  stopwatch_ctrl #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SEC_EN(SEC_EN), .BTN_SS(BTN_SS),
    .BTN_LAP(BTN_LAP), .BTN_CLR(BTN_CLR), .CNT_EN(CNT_EN), .CNT_CLR(CNT_CLR),
    .HOLD(HOLD), .RUN_LED(RUN_LED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    t++;
    if (sec_auto) SEC_EN = (t % 10 == 0);
    if (CNT_EN) n_en++;
    if (CNT_CLR) n_clr++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) BTN_SS = v;
    else if (b == 1) BTN_LAP = v;
    else BTN_CLR = v;
  endtask

  // hold long enough for the transition, then let the release settle
  task automatic press(input int b);
    set_btn(b, 1'b1);
    steps(10);
    set_btn(b, 1'b0);
    steps(8);
  endtask

  initial begin
    #2;
    chk("rst_run_led", RUN_LED, 0);
    chk("rst_hold", HOLD, 0);
    chk("rst_cnt_en", CNT_EN, 0);
    chk("rst_cnt_clr", CNT_CLR, 0);
    chk("rst_state", dut.state_q, 0);
    #10 RESET_N = 1'b1;
    steps(2);
    sec_auto = 1'b1;

    // clean SS held 20 cycles: press at edge 7, RUN at edge 8, once only
    BTN_SS = 1'b1;
    steps(7);
    chk("ss_lat_pre", RUN_LED, 0);
    steps(1);
    chk("ss_lat_run_led", RUN_LED, 1);
    chk("ss_lat_state", dut.state_q, 1);
    steps(12);
    BTN_SS = 1'b0;
    steps(8);
    chk("ss_held_once", dut.state_q, 1);
    n_en = 0;
    steps(30);
    chk("run_en_count", 8'(n_en), 3);
    for (int i = 0; i < 10 && !SEC_EN; i++) step();
    chk("sec_en_seen", SEC_EN, 1);
    step();
    chk("cnt_en_follow", CNT_EN, 1);
    step();
    chk("cnt_en_single", CNT_EN, 0);

    // lap view holds the display while counting continues
    press(1);
    chk("lap_hold", HOLD, 1);
    chk("lap_state", dut.state_q, 2);
    n_en = 0;
    steps(30);
    chk("lap_en_count", 8'(n_en), 3);
    press(1);
    chk("lap2_hold", HOLD, 0);
    chk("lap2_state", dut.state_q, 1);
    chk("lap2_run_led", RUN_LED, 1);

    // pause stops counting, clear returns to idle with a single clear pulse
    press(0);
    chk("pause_state", dut.state_q, 3);
    chk("pause_run_led", RUN_LED, 0);
    n_en = 0;
    steps(30);
    chk("pause_en_count", 8'(n_en), 0);
    n_clr = 0;
    BTN_CLR = 1'b1;
    steps(7);
    chk("clr_pre", CNT_CLR, 0);
    steps(1);
    chk("clr_pulse", CNT_CLR, 1);
    chk("clr_state", dut.state_q, 0);
    steps(1);
    chk("clr_drop", CNT_CLR, 0);
    steps(9);
    BTN_CLR = 1'b0;
    steps(8);
    chk("clr_count", 8'(n_clr), 1);

    // bounce 1-0-1 at 2-cycle spacing: only the final rise counts
    BTN_SS = 1'b1; steps(2);
    BTN_SS = 1'b0; steps(2);
    BTN_SS = 1'b1;
    steps(7);
    chk("bounce_pre", RUN_LED, 0);
    chk("bounce_pre_state", dut.state_q, 0);
    steps(1);
    chk("bounce_run", RUN_LED, 1);
    steps(4);
    BTN_SS = 1'b0;
    steps(8);

    // simultaneous CLR and SS in PAUSE: clear wins
    press(0);
    chk("pause2_state", dut.state_q, 3);
    n_clr = 0;
    BTN_CLR = 1'b1;
    BTN_SS = 1'b1;
    steps(8);
    chk("both_state", dut.state_q, 0);
    chk("both_cnt_clr", CNT_CLR, 1);
    chk("both_run_led", RUN_LED, 0);
    steps(2);
    BTN_CLR = 1'b0;
    BTN_SS = 1'b0;
    steps(8);
    chk("both_clr_count", 8'(n_clr), 1);
    chk("both_run_led_after", RUN_LED, 0);

    // SS pulse coinciding with SEC_EN in RUN, then in PAUSE
    press(0);
    sec_auto = 1'b0;
    SEC_EN = 1'b0;
    steps(2);
    chk("coin_run", dut.state_q, 1);
    BTN_SS = 1'b1;
    steps(7);
    SEC_EN = 1'b1;
    step();
    SEC_EN = 1'b0;
    chk("coin_final_en", CNT_EN, 1);
    chk("coin_paused", dut.state_q, 3);
    step();
    chk("coin_en_drop", CNT_EN, 0);
    BTN_SS = 1'b0;
    steps(8);
    BTN_SS = 1'b1;
    steps(7);
    SEC_EN = 1'b1;
    step();
    SEC_EN = 1'b0;
    chk("pause_coin_en", CNT_EN, 0);
    chk("pause_coin_run", dut.state_q, 1);
    BTN_SS = 1'b0;
    steps(8);
    SEC_EN = 1'b1;
    step();
    SEC_EN = 1'b0;
    chk("resume_en", CNT_EN, 1);

    // asynchronous reset during LAP
    press(1);
    chk("lap3_hold", HOLD, 1);
    SEC_EN = 1'b1;
    step();
    SEC_EN = 1'b0;
    chk("lap3_cnt_en", CNT_EN, 1);
    RESET_N = 1'b0;
    #1;
    chk("arst_cnt_en", CNT_EN, 0);
    chk("arst_hold", HOLD, 0);
    chk("arst_run_led", RUN_LED, 0);
    chk("arst_state", dut.state_q, 0);
    #3 RESET_N = 1'b1;
    step();
    BTN_SS = 1'b1;
    steps(7);
    chk("post_rst_pre", RUN_LED, 0);
    steps(1);
    chk("post_rst_run", RUN_LED, 1);
    BTN_SS = 1'b0;
    steps(8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
